issue_ctrl: RTL and testbench

- Issue controller between the instruction decoder (ID) and the execute units (ALU/BRU/LSU/CSR).
- Keeps a per-register scoreboard of outstanding writes and stalls ID on RAW hazards and on in-flight overflow.
- Serialises control flow: after a branch or jump issues, no further issue until the BRU resolves it.
- Drains the machine before ecall, ebreak, fence, fence.i and CSR instructions. Keeps a stall performance counter.

---
 rtl/issue_ctrl_pkg.sv | 18 +
 rtl/issue_scoreboard.sv | 81 ++++++++
 rtl/issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller slice.
// Contents: register-index width, the x0 index, register count, and the
//           issue FSM state encoding.
package issue_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef logic [1:0] issue_state_t;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_BR_WAIT = 2'd1;
  localparam logic [1:0] ST_SERIAL  = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register scoreboard of outstanding writes.
// Ports:
//   clock_i, reset_i         clock, async active-high reset
//   inc_i / inc_addr_i       an issuing instruction will write inc_addr_i
//   dec_i / dec_addr_i       a writeback to dec_addr_i retires
//   rd_addr_a_i/rd_addr_b_i  source register read ports
//   retire_empty_i           a retire was seen with nothing in flight
//   pend_a_o / pend_b_o      read port register has writes pending
//   sat_o                    inc_addr_i counter is saturated
//   sb_err_o                 sticky scoreboard error
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int REG_CNT_W = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 inc_i,
  input  logic [REG_IDX_W-1:0] inc_addr_i,
  input  logic                 dec_i,
  input  logic [REG_IDX_W-1:0] dec_addr_i,
  input  logic [REG_IDX_W-1:0] rd_addr_a_i,
  input  logic [REG_IDX_W-1:0] rd_addr_b_i,
  input  logic                 retire_empty_i,
  output logic                 pend_a_o,
  output logic                 pend_b_o,
  output logic                 sat_o,
  output logic                 sb_err_o
);

  localparam logic [REG_CNT_W-1:0] PEND_MAX = '1;

  // Entry 0 exists only so reads of x0 index cleanly; it is held at zero.
  logic [REG_CNT_W-1:0] pend_q [NUM_REGS];
  logic [REG_CNT_W-1:0] pend_d [NUM_REGS];
  logic                 sb_err_q, sb_err_d;

  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      logic inc_hit, dec_hit;
      inc_hit = inc_i && (inc_addr_i == REG_IDX_W'(i));
      dec_hit = dec_i && (dec_addr_i == REG_IDX_W'(i));
      // Simultaneous inc and dec of one register cancel out.
      if (inc_hit && !dec_hit && pend_q[i] != PEND_MAX) begin
        pend_d[i] = pend_q[i] + 1'b1;
      end else if (dec_hit && !inc_hit && pend_q[i] != '0) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (retire_empty_i) begin
      sb_err_d = 1'b1;
    end
    if (dec_i && dec_addr_i != REG_X0 && pend_q[dec_addr_i] == '0) begin
      sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign pend_a_o = (pend_q[rd_addr_a_i] != '0);
  assign pend_b_o = (pend_q[rd_addr_b_i] != '0);
  assign sat_o    = (pend_q[inc_addr_i] == PEND_MAX);
  assign sb_err_o = sb_err_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between the decoder and the execute units.
// Stalls on RAW hazards, in-flight overflow and pending-counter saturation,
// serialises control flow until the BRU resolves, drains before serial
// (CSR/fence/ecall/ebreak) instructions and after flush.
// Ports (inputs _i, outputs _o):
//   clock_i, reset_i                 clock, async active-high reset
//   id_*_i                           decoded instruction fields
//   ex_ready_i, bru_resolve_i        execute backpressure, branch resolved
//   wb_valid_i, wb_waddr_i, wb_we_i  retire / writeback
//   flush_i                          kill ID instruction, drain
//   id_ready_o, issue_fire_o         issue decision (combinational)
//   stall_raw_o                      RAW-caused stall (combinational)
//   inflight_cnt_o, stall_cycles_o   registered counters
//   sb_err_o                         sticky scoreboard error
//
// state   | meaning
// RUN     | normal issue
// BR_WAIT | branch/jump issued, waiting for bru_resolve
// SERIAL  | serial instruction issued, waiting for it to retire
// DRAIN   | flushed, waiting for in-flight work to retire
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter  int MAX_INFLIGHT = 4,
  parameter  int REG_CNT_W    = 2,
  parameter  int PERF_W       = 32,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs1_ren_i,
  input  logic                 id_rs2_ren_i,
  input  logic                 id_rf_we_i,
  input  logic [REG_IDX_W-1:0] id_rf_waddr_i,
  input  logic                 id_is_ctrl_i,
  input  logic                 id_is_serial_i,
  input  logic                 ex_ready_i,
  input  logic                 bru_resolve_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_waddr_i,
  input  logic                 wb_we_i,
  input  logic                 flush_i,
  output logic                 id_ready_o,
  output logic                 issue_fire_o,
  output logic                 stall_raw_o,
  output logic [CNT_W-1:0]     inflight_cnt_o,
  output logic [PERF_W-1:0]    stall_cycles_o,
  output logic                 sb_err_o
);

  issue_state_t         state_q, state_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [PERF_W-1:0]    stall_q, stall_d;

  logic pend_rs1, pend_rs2, rd_sat;
  logic hazard, rd_tracked, sb_inc, sb_dec, retire_empty;

  assign rd_tracked   = id_rf_we_i && (id_rf_waddr_i != REG_X0);
  assign sb_inc       = issue_fire_o && rd_tracked;
  assign sb_dec       = wb_valid_i && wb_we_i && (wb_waddr_i != REG_X0);
  assign retire_empty = wb_valid_i && (inflight_q == '0);

  issue_scoreboard #(
    .REG_CNT_W (REG_CNT_W)
  ) u_sb (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .inc_i          (sb_inc),
    .inc_addr_i     (id_rf_waddr_i),
    .dec_i          (sb_dec),
    .dec_addr_i     (wb_waddr_i),
    .rd_addr_a_i    (id_rs1_i),
    .rd_addr_b_i    (id_rs2_i),
    .retire_empty_i (retire_empty),
    .pend_a_o       (pend_rs1),
    .pend_b_o       (pend_rs2),
    .sat_o          (rd_sat),
    .sb_err_o       (sb_err_o)
  );

  // No writeback bypass: hazards are judged on registered counters only.
  assign hazard = id_valid_i &&
                  ((id_rs1_ren_i && id_rs1_i != REG_X0 && pend_rs1) ||
                   (id_rs2_ren_i && id_rs2_i != REG_X0 && pend_rs2));

  // Reset is folded in so the issue decision reads 0 while reset is held.
  assign id_ready_o = !reset_i && (state_q == ST_RUN) && ex_ready_i &&
                      !hazard && !flush_i &&
                      (inflight_q < CNT_W'(MAX_INFLIGHT)) &&
                      !(rd_tracked && rd_sat) &&
                      !(id_is_serial_i && inflight_q != '0);

  assign issue_fire_o = id_valid_i && id_ready_o;
  assign stall_raw_o  = hazard;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (issue_fire_o && id_is_ctrl_i) begin
          state_d = ST_BR_WAIT;
        end else if (issue_fire_o && id_is_serial_i) begin
          state_d = ST_SERIAL;
        end
      end
      ST_BR_WAIT: begin
        if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (bru_resolve_i) begin
          state_d = ST_RUN;
        end
      end
      ST_SERIAL: begin
        if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (inflight_q == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!flush_i && inflight_q == '0) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_fire_o, wb_valid_i})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid_i && !id_ready_o) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      inflight_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

  assign inflight_cnt_o = inflight_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_issue_ctrl;

  localparam int MAXI     = 4;
  localparam int PEND_MAX = 3;

  logic        clock_i, reset_i;
  logic        id_valid_i, id_rs1_ren_i, id_rs2_ren_i, id_rf_we_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rf_waddr_i, wb_waddr_i;
  logic        id_is_ctrl_i, id_is_serial_i, ex_ready_i, bru_resolve_i;
  logic        wb_valid_i, wb_we_i, flush_i;
  logic        id_ready_o, issue_fire_o, stall_raw_o, sb_err_o;
  logic [2:0]  inflight_cnt_o;
  logic [31:0] stall_cycles_o;

  issue_ctrl #(.MAX_INFLIGHT(MAXI), .REG_CNT_W(2), .PERF_W(32)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .id_rf_we_i(id_rf_we_i), .id_rf_waddr_i(id_rf_waddr_i),
    .id_is_ctrl_i(id_is_ctrl_i), .id_is_serial_i(id_is_serial_i),
    .ex_ready_i(ex_ready_i), .bru_resolve_i(bru_resolve_i),
    .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i), .wb_we_i(wb_we_i),
    .flush_i(flush_i),
    .id_ready_o(id_ready_o), .issue_fire_o(issue_fire_o),
    .stall_raw_o(stall_raw_o), .inflight_cnt_o(inflight_cnt_o),
    .stall_cycles_o(stall_cycles_o), .sb_err_o(sb_err_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model
  typedef enum {M_RUN, M_BR, M_SER, M_DRAIN} mstate_e;
  typedef struct {bit we; logic [4:0] rd;} instr_t;

  int          m_pend [32];
  int          m_infl;
  mstate_e     m_state;
  logic [31:0] m_stall;
  bit          m_err;
  instr_t      q[$];

  function automatic bit m_hazard();
    bit r1, r2;
    r1 = id_rs1_ren_i && id_rs1_i != 0 && m_pend[id_rs1_i] > 0;
    r2 = id_rs2_ren_i && id_rs2_i != 0 && m_pend[id_rs2_i] > 0;
    return id_valid_i && (r1 || r2);
  endfunction

  function automatic bit m_ready();
    if (reset_i || m_state != M_RUN || !ex_ready_i || flush_i) return 1'b0;
    if (m_hazard()) return 1'b0;
    if (m_infl >= MAXI) return 1'b0;
    if (id_rf_we_i && id_rf_waddr_i != 0 && m_pend[id_rf_waddr_i] >= PEND_MAX) return 1'b0;
    if (id_is_serial_i && m_infl != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_infl  = 0;
    m_state = M_RUN;
    m_stall = '0;
    m_err   = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_ren_i = 0; id_rs2_ren_i = 0;
    id_rf_we_i = 0; id_rf_waddr_i = 0; id_is_ctrl_i = 0; id_is_serial_i = 0;
    ex_ready_i = 1; bru_resolve_i = 0; wb_valid_i = 0; wb_waddr_i = 0; wb_we_i = 0;
    flush_i = 0;
  endtask

  task automatic set_instr(input bit v, input logic [4:0] rs1, input bit r1en,
                           input logic [4:0] rs2, input bit r2en, input bit we,
                           input logic [4:0] rd, input bit ctrl, input bit ser);
    id_valid_i = v; id_rs1_i = rs1; id_rs1_ren_i = r1en; id_rs2_i = rs2;
    id_rs2_ren_i = r2en; id_rf_we_i = we; id_rf_waddr_i = rd;
    id_is_ctrl_i = ctrl; id_is_serial_i = ser;
  endtask

  // Retire the oldest outstanding instruction this cycle when en is set.
  task automatic set_wb(input bit en);
    instr_t t;
    if (en && q.size() > 0) begin
      t = q.pop_front();
      wb_valid_i = 1; wb_we_i = t.we; wb_waddr_i = t.rd;
    end else begin
      wb_valid_i = 0; wb_we_i = 0; wb_waddr_i = 0;
    end
  endtask

  task automatic cycle();
    bit haz, rdy, fire, inc, dec;
    int old_infl;
    instr_t t;
    #1;
    haz  = m_hazard();
    rdy  = m_ready();
    fire = id_valid_i && rdy;
    check("id_ready", id_ready_o, rdy);
    check("issue_fire", issue_fire_o, fire);
    check("stall_raw", stall_raw_o, haz);
    @(posedge clock_i);
    old_infl = m_infl;
    if (id_valid_i && !rdy) m_stall = m_stall + 1;
    if (fire) begin
      t.we = id_rf_we_i; t.rd = id_rf_waddr_i;
      q.push_back(t);
    end
    inc = fire && id_rf_we_i && id_rf_waddr_i != 0;
    dec = wb_valid_i && wb_we_i && wb_waddr_i != 0;
    if (dec && m_pend[wb_waddr_i] == 0) m_err = 1;
    if (!(inc && dec && id_rf_waddr_i == wb_waddr_i)) begin
      if (inc && m_pend[id_rf_waddr_i] < PEND_MAX) m_pend[id_rf_waddr_i]++;
      if (dec && m_pend[wb_waddr_i] > 0) m_pend[wb_waddr_i]--;
    end
    if (wb_valid_i && m_infl == 0) m_err = 1;
    if (fire && !wb_valid_i) m_infl++;
    else if (!fire && wb_valid_i && m_infl > 0) m_infl--;
    case (m_state)
      M_RUN:   if (flush_i) m_state = M_DRAIN;
               else if (fire && id_is_ctrl_i) m_state = M_BR;
               else if (fire && id_is_serial_i) m_state = M_SER;
      M_BR:    if (flush_i) m_state = M_DRAIN;
               else if (bru_resolve_i) m_state = M_RUN;
      M_SER:   if (flush_i) m_state = M_DRAIN;
               else if (old_infl == 0) m_state = M_RUN;
      M_DRAIN: if (!flush_i && old_infl == 0) m_state = M_RUN;
      default: m_state = M_RUN;
    endcase
    #1;
    check("inflight_cnt", 32'(inflight_cnt_o), 32'(m_infl));
    check("stall_cycles", stall_cycles_o, m_stall);
    check("sb_err", sb_err_o, m_err);
  endtask

  task automatic do_reset();
    reset_i = 1;
    idle();
    id_valid_i = 1;
    #2;
    check("rst_id_ready", id_ready_o, 0);
    check("rst_issue_fire", issue_fire_o, 0);
    check("rst_stall_raw", stall_raw_o, 0);
    check("rst_inflight", 32'(inflight_cnt_o), 0);
    check("rst_stall_cycles", stall_cycles_o, 0);
    check("rst_sb_err", sb_err_o, 0);
    model_clear();
    @(posedge clock_i);
    #1;
    reset_i = 0;
    idle();
  endtask

  task automatic drain();
    int n = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bru_resolve_i = 0; flush_i = 0;
    while ((q.size() > 0 || m_state != M_RUN) && n < 30) begin
      if (m_state == M_BR) bru_resolve_i = 1;
      set_wb(1);
      cycle();
      bru_resolve_i = 0;
      n++;
    end
    set_wb(0);
    if (n >= 30) check("drain_timeout", 1, 0);
  endtask

  initial begin
    reset_i = 1;
    idle();
    model_clear();
    do_reset();

    // RAW on x5, released the cycle after its writeback
    set_instr(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    set_instr(1, 5, 1, 0, 0, 1, 6, 0, 0); cycle(); cycle(); cycle();
    check("raw_stall_flag", stall_raw_o, 1);
    set_wb(1); cycle();
    check("raw_stall_count", stall_cycles_o, 32'd4);
    set_wb(0); #1;
    check("raw_release", id_ready_o, 1);
    cycle();
    drain();

    // x0 is never tracked
    set_instr(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    set_instr(1, 0, 1, 0, 1, 1, 9, 0, 0); #1;
    check("x0_no_stall", id_ready_o, 1);
    cycle();
    drain();

    // x7 saturation at 3 pending writes
    repeat (3) begin set_instr(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle(); end
    #1;
    check("sat_block", id_ready_o, 0);
    check("sat_not_raw", stall_raw_o, 0);
    cycle();
    set_wb(1); cycle();
    set_wb(0); cycle();
    set_wb(1); cycle();
    set_wb(1); cycle();
    set_wb(0); cycle();
    cycle();
    drain();

    // global in-flight limit
    for (int r = 1; r <= 4; r++) begin
      set_instr(1, 0, 0, 0, 0, 1, 5'(r), 0, 0); cycle();
    end
    check("global_full", 32'(inflight_cnt_o), 4);
    set_instr(1, 0, 0, 0, 0, 1, 8, 0, 0); cycle();
    set_wb(1); cycle();
    set_wb(0); #1;
    check("global_release", id_ready_o, 1);
    cycle();
    drain();

    // branch, then resolve together with flush
    set_instr(1, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle(); cycle();
    bru_resolve_i = 1; flush_i = 1; cycle();
    bru_resolve_i = 0; flush_i = 0; cycle();
    set_wb(1); cycle();
    set_wb(0); cycle(); cycle();
    drain();

    // serial instruction waits for an empty machine and blocks until retired
    set_instr(1, 0, 0, 0, 0, 1, 10, 0, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 1, 11, 0, 0); cycle();
    set_instr(1, 0, 0, 0, 0, 1, 12, 0, 1); cycle();
    set_wb(1); cycle(); cycle();
    set_wb(0); cycle(); cycle();
    set_instr(1, 0, 0, 0, 0, 1, 13, 0, 0); cycle(); cycle();
    set_wb(1); cycle();
    set_wb(0); cycle(); cycle(); cycle();
    drain();

    // random traffic, with a reset dropped in halfway
    for (int i = 0; i < 2000; i++) begin
      bit ctrl;
      if (i == 1000) do_reset();
      ctrl = ($urandom % 16) == 0;
      set_instr(($urandom % 4) != 0, 5'($urandom % 8), $urandom % 2,
                5'($urandom % 8), $urandom % 2, ($urandom % 4) != 0,
                5'($urandom % 8), ctrl, !ctrl && ($urandom % 20) == 0);
      ex_ready_i    = ($urandom % 8) != 0;
      bru_resolve_i = (m_state == M_BR && ($urandom % 3) == 0) || ($urandom % 30) == 0;
      flush_i       = ($urandom % 40) == 0;
      set_wb(($urandom % 10) < 4);
      cycle();
    end
    drain();

    // writeback with nothing pending sets the sticky error
    idle();
    wb_valid_i = 1; wb_we_i = 1; wb_waddr_i = 9; cycle();
    idle(); cycle(); cycle(); cycle();
    check("err_sticky", sb_err_o, 1);
    do_reset();
    check("err_cleared", sb_err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
